// File: rtl/pcie_ser_arbiter.sv
// Two-port arbiter feeding a DATA_WIDTH-bit parallel-to-serial shifter, MSB first.
// Latency: a word accepted at edge N drives its MSB during cycle N+1 and its LSB during cycle N+DATA_WIDTH.
// Backpressure: a ready goes high only in the grant window, and only for the winner; words follow back to back.
//
// Ports:
//   clk, reset (async, active-low), tx_en (gates new grants only)
//   in0_valid/in0_ready/in0_data : high-priority source (DLLP / ordered sets)
//   in1_valid/in1_ready/in1_data : low-priority source (TLPs)
//   ser_bit, ser_valid, ser_src, ser_last : serial output stream
//
// Optional feature: define PCIE_SER_ARB_FAIR_EN to add a port-0 streak counter.
// The counter hands the window to port 1 after MAX_HI consecutive port-0 grants made while port 1 waits.
// In the default build, priority is strict and port 1 can starve.

module pcie_ser_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int MAX_HI     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_en,
    input  logic                  in0_valid,
    output logic                  in0_ready,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in1_valid,
    output logic                  in1_ready,
    input  logic [DATA_WIDTH-1:0] in1_data,
    output logic                  ser_bit,
    output logic                  ser_valid,
    output logic                  ser_src,
    output logic                  ser_last
);

    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [CW-1:0]         r_bit_cnt;
    logic                  r_src;

    logic w_window;
    logic w_force1;
    logic w_pick0;
    logic w_pick1;
    logic w_hs0;
    logic w_hs1;

    // The window opens in IDLE, or on the LSB cycle of a word so the next word follows with no gap.
    // Qualifying with reset keeps both readies low while reset is held.
    assign w_window = reset & tx_en & ((r_state == IDLE) || (r_bit_cnt == '0));

`ifdef PCIE_SER_ARB_FAIR_EN
    logic [3:0] r_streak;

    assign w_force1 = in1_valid & (r_streak == 4'(MAX_HI));

    // Count only port-0 grants that actually made port 1 wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_streak <= 4'd0;
        end else if (w_hs0) begin
            if (!in1_valid)
                r_streak <= 4'd0;
            else if (r_streak != 4'hF)
                r_streak <= r_streak + 4'd1;
        end else if (w_hs1) begin
            r_streak <= 4'd0;
        end
    end
`else
    assign w_force1 = 1'b0;
`endif

    assign w_pick1 = in1_valid & (~in0_valid | w_force1);
    assign w_pick0 = in0_valid & ~w_pick1;

    assign in0_ready = w_window & w_pick0;
    assign in1_ready = w_window & w_pick1;

    assign w_hs0 = in0_valid & in0_ready;
    assign w_hs1 = in1_valid & in1_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_src     <= 1'b0;
        end else begin
            if (w_hs0 || w_hs1) begin
                r_shreg   <= w_hs0 ? in0_data : in1_data;
                r_bit_cnt <= CW'(DATA_WIDTH - 1);
                r_src     <= w_hs1;
                r_state   <= SHIFT;
            end else if (r_state == SHIFT) begin
                if (r_bit_cnt != '0) begin
                    r_shreg   <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt - 1'b1;
                end else begin
                    r_state <= IDLE;
                end
            end
        end
    end

    // The shift register keeps the stale LSB-shifted word in IDLE, so the output bit is gated.
    assign ser_valid = (r_state == SHIFT);
    assign ser_bit   = ser_valid & r_shreg[DATA_WIDTH-1];
    assign ser_last  = ser_valid & (r_bit_cnt == '0);
    assign ser_src   = r_src;

endmodule

// File: tb/tb_pcie_ser_arbiter.sv
// Directed bench for pcie_ser_arbiter with DATA_WIDTH=8 and MAX_HI=2.
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled on the falling edge.
// Expected serial bits, sources and readies are all hand-derived constants.

module tb_pcie_ser_arbiter;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          tx_en;
    logic          in0_valid;
    logic          in0_ready;
    logic [DW-1:0] in0_data;
    logic          in1_valid;
    logic          in1_ready;
    logic [DW-1:0] in1_data;
    logic          ser_bit;
    logic          ser_valid;
    logic          ser_src;
    logic          ser_last;

    int n_tests = 0;
    int n_fail  = 0;

    pcie_ser_arbiter #(.DATA_WIDTH(DW), .MAX_HI(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_en     (tx_en),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .ser_bit   (ser_bit),
        .ser_valid (ser_valid),
        .ser_src   (ser_src),
        .ser_last  (ser_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Checks one full word on the serial port, one bit per falling edge.
    // last_rdy is {in1_ready,in0_ready} expected on the LSB cycle.
    // When drop_at matches a bit index, tx_en is cleared right after that bit is checked.
    task automatic shift_chk(input logic [DW-1:0] d, input logic src,
                             input logic [1:0] last_rdy, input int drop_at);
        for (int i = 0; i < DW; i++) begin
            @(negedge clk);
            chk("ser_valid", ser_valid, 1);
            chk("ser_bit",   ser_bit,   d[DW-1-i]);
            chk("ser_src",   ser_src,   src);
            chk("ser_last",  ser_last,  (i == DW-1) ? 1 : 0);
            chk("ready",     {in1_ready, in0_ready}, (i == DW-1) ? last_rdy : 2'b00);
            if (i == drop_at) tx_en = 1'b0;
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

`ifdef PCIE_SER_ARB_FAIR_EN
    logic [5:0] fair_order = 6'b100100;   // bit w = source of word w: 0,0,1,0,0,1
`else
    logic [5:0] fair_order = 6'b000000;
`endif

    initial begin
        // Reset state, with every input pushing for a grant.
        reset = 1'b0; tx_en = 1'b1;
        in0_valid = 1'b1; in0_data = 8'h11;
        in1_valid = 1'b1; in1_data = 8'h22;
        #2;
        chk("rst_valid", ser_valid, 0);
        chk("rst_bit",   ser_bit,   0);
        chk("rst_last",  ser_last,  0);
        chk("rst_src",   ser_src,   0);
        chk("rst_rdy",   {in1_ready, in0_ready}, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy_clk", {in1_ready, in0_ready}, 2'b00);
        chk("rst_valid_clk", ser_valid, 0);
        in0_valid = 1'b0; in1_valid = 1'b0;
        #2 reset = 1'b1;

        // Single word from port 1: A5.
        drive_edge();
        in1_valid = 1'b1; in1_data = 8'hA5;
        @(negedge clk);
        chk("single_rdy", {in1_ready, in0_ready}, 2'b10);
        drive_edge();
        in1_valid = 1'b0; in1_data = 8'h00;
        shift_chk(8'hA5, 1'b1, 2'b00, -1);
        @(negedge clk);
        chk("single_idle_valid", ser_valid, 0);
        chk("single_idle_bit",   ser_bit,   0);
        chk("single_idle_src",   ser_src,   1);

        // Back-to-back FF then 00 from port 0.
        // The data changes right after acceptance, which must not disturb FF.
        drive_edge();
        in0_valid = 1'b1; in0_data = 8'hFF;
        @(negedge clk);
        chk("b2b_rdy", {in1_ready, in0_ready}, 2'b01);
        drive_edge();
        in0_data = 8'h00;
        shift_chk(8'hFF, 1'b0, 2'b01, -1);
        drive_edge();
        in0_valid = 1'b0;
        shift_chk(8'h00, 1'b0, 2'b00, -1);
        @(negedge clk);
        chk("b2b_idle", ser_valid, 0);

        // Contention from IDLE: port 0 first, then port 1 at ser_last.
        drive_edge();
        in0_valid = 1'b1; in0_data = 8'h96;
        in1_valid = 1'b1; in1_data = 8'h5A;
        @(negedge clk);
        chk("cont_rdy", {in1_ready, in0_ready}, 2'b01);
        drive_edge();
        in0_valid = 1'b0;
        shift_chk(8'h96, 1'b0, 2'b10, -1);
        drive_edge();
        in1_valid = 1'b0;
        shift_chk(8'h5A, 1'b1, 2'b00, -1);
        @(negedge clk);
        chk("cont_idle", ser_valid, 0);

        // Both ports continuously valid: six words back to back.
        drive_edge();
        in0_valid = 1'b1; in0_data = 8'h81;
        in1_valid = 1'b1; in1_data = 8'h7E;
        @(negedge clk);
        chk("fair_rdy0", {in1_ready, in0_ready}, fair_order[0] ? 2'b10 : 2'b01);
        for (int w = 0; w < 6; w++) begin
            logic nxt;
            nxt = (w == 5) ? 1'b0 : fair_order[w+1];
            shift_chk(fair_order[w] ? 8'h7E : 8'h81, fair_order[w],
                      nxt ? 2'b10 : 2'b01, -1);
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        @(negedge clk);
        chk("fair_idle", ser_valid, 0);

        // tx_en falls during bit 3 of 3C: the word completes, then no grant.
        drive_edge();
        in0_valid = 1'b1; in0_data = 8'h3C;
        @(negedge clk);
        chk("txen_rdy", {in1_ready, in0_ready}, 2'b01);
        drive_edge();
        in1_valid = 1'b1;
        shift_chk(8'h3C, 1'b0, 2'b00, 3);
        repeat (2) begin
            @(negedge clk);
            chk("txen_idle_valid", ser_valid, 0);
            chk("txen_idle_rdy", {in1_ready, in0_ready}, 2'b00);
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        tx_en = 1'b1;

        // Reset lands on bit 5 of E7, where the serial bit is 1.
        drive_edge();
        in1_valid = 1'b1; in1_data = 8'hE7;
        drive_edge();
        in1_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("pre_rst_bit", ser_bit, (i < 3 || i == 5) ? 1 : 0);
        end
        #1 reset = 1'b0;
        #1;
        chk("async_rst_valid", ser_valid, 0);
        chk("async_rst_bit",   ser_bit,   0);
        chk("async_rst_last",  ser_last,  0);
        in1_valid = 1'b1; in1_data = 8'hB4;
        drive_edge();
        chk("rst_hold_rdy", {in1_ready, in0_ready}, 2'b00);
        chk("rst_hold_valid", ser_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", {in1_ready, in0_ready}, 2'b10);
        chk("post_rst_valid", ser_valid, 0);
        drive_edge();
        in1_valid = 1'b0;
        shift_chk(8'hB4, 1'b1, 2'b00, -1);
        @(negedge clk);
        chk("post_rst_idle", ser_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_ser_arbiter.md
PCIE_SER_ARBITER -- requirements
Module: pcie_ser_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 128: width of one parallel word; SHALL be a power of two, >= 8.
REQ-002 Parameter MAX_HI, default 4: consecutive port-0 grants allowed while port 1 waits (fair mode only); range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tx_en  input  1  permits new grants; does not abort a word already shifting.
REQ-006 in0_valid / in0_ready / in0_data  in/out/in  1/1/DATA_WIDTH  port 0 (DLLP/ordered-set source), high priority.
REQ-007 in1_valid / in1_ready / in1_data  in/out/in  1/1/DATA_WIDTH  port 1 (TLP source), low priority.
REQ-008 ser_bit  output  1  serial bit, MSB of the word first.
REQ-009 ser_valid  output  1  ser_bit carries a word bit this cycle.
REQ-010 ser_src  output  1  source port of the word currently shifting.
REQ-011 ser_last  output  1  final bit (LSB) of the current word on ser_bit.

Function
REQ-012 States: IDLE (no word) and SHIFT (word in progress); internal DATA_WIDTH-bit shift register and $clog2(DATA_WIDTH)-bit down-counter bit_cnt.
REQ-013 Grant window open when tx_en=1 and (state=IDLE or (state=SHIFT and bit_cnt=0)).
REQ-014 In grant window, inX_ready SHALL be 1 combinationally for the arbitration winner only; never both readies 1 in one cycle.
REQ-015 Arbitration: port 0 wins whenever in0_valid=1, except as modified by REQ-027; port 1 wins when only in1_valid=1.
REQ-016 Handshake = inX_valid & inX_ready; on handshake the word loads, bit_cnt <= DATA_WIDTH-1, ser_src <= X, state <= SHIFT.
REQ-017 Latency: word accepted at edge N drives its MSB on ser_bit during cycle N+1; its LSB in cycle N+DATA_WIDTH.
REQ-018 SHIFT, bit_cnt>0: shift register shifts left one bit, bit_cnt decrements, every cycle; no stall.
REQ-019 SHIFT, bit_cnt=0 with handshake: next word loads, zero gap cycles between words.
REQ-020 SHIFT, bit_cnt=0 without handshake (no valid or tx_en=0): state <= IDLE.
REQ-021 ser_valid=1 exactly when state=SHIFT; ser_last=1 exactly when state=SHIFT and bit_cnt=0.
REQ-022 In IDLE: ser_bit=0, ser_src holds last value, ser_last=0.
REQ-023 tx_en falling mid-word: current word completes all DATA_WIDTH bits, then IDLE.
REQ-024 inX_data sampled only at handshake edge; changes at other times have no effect.

Reset
REQ-025 reset=0 asynchronously forces: state=IDLE, shift register=0, bit_cnt=0, ser_src=0, fairness counter=0; thus ser_bit=0, ser_valid=0, ser_last=0, in0_ready=in1_ready=0.
REQ-026 Reset asserted mid-word discards the word; after release, first grant occurs no earlier than the first rising edge with reset=1.

Configuration
REQ-027 Macro PCIE_SER_ARB_FAIR_EN defined: 4-bit streak counter increments on each port-0 grant made while in1_valid=1, clears on any port-1 grant or a port-0 grant with in1_valid=0; when streak=MAX_HI and in1_valid=1, port 1 wins the window.
REQ-028 Macro undefined: no streak counter; strict priority per REQ-015; port 1 may starve indefinitely.

Verification (DATA_WIDTH=8, MAX_HI=2)
REQ-029 Single word: in1 presents 8'hA5 from IDLE -> in1_ready=1 one cycle; ser_bit 1,0,1,0,0,1,0,1 over next 8 cycles, ser_src=1, ser_last on 8th, then IDLE.
REQ-030 Back-to-back: in0 streams 8'hFF then 8'h00 -> 16 consecutive ser_valid cycles, eight 1s then eight 0s, no gap.
REQ-031 Contention: both valid from IDLE -> in0 granted first; in1 granted at ser_last of in0 word (in0 then idle).
REQ-032 Fairness (macro defined): in0 and in1 continuously valid -> grant order 0,0,1,0,0,1; macro undefined -> only port 0 granted.
REQ-033 tx_en dropped at bit 3 of 8'h3C -> word completes, ser_last asserted, then IDLE with no ready despite valids.
REQ-034 reset asserted at bit 5 -> ser_valid=0 and ser_bit=0 immediately (asynchronously); after release, a valid word starts cleanly with its MSB.
